// File: rtl/multiplier_if.sv
// Issue-side bundle for the shift-and-add multiplier: launch/busy handshake, operands and product.
// Shares the launch/busy protocol with the restoring divider so both sit behind one issue port.
interface multiplier_if #(
   parameter int unsigned WIDTH = 4
);
   logic                 launch;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output launch, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  launch, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/multiplier.sv
// Unsigned iterative shift-and-add multiplier, one multiplier bit per cycle, double-width product.
// Build option MULTIPLIER_EARLY_EXIT_EN finishes as soon as no set multiplier bits remain.
module multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input logic         clk,
   input logic         reset,
   multiplier_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e               state_q, state_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CntW-1:0]      it_count_q, it_count_d;
   logic                 last_step;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         done_q     <= 1'b0;
         mcand_q    <= '0;
         mplr_q     <= '0;
         acc_q      <= '0;
         it_count_q <= '0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         mcand_q    <= mcand_d;
         mplr_q     <= mplr_d;
         acc_q      <= acc_d;
         it_count_q <= it_count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      mcand_d    = mcand_q;
      mplr_d     = mplr_q;
      acc_d      = acc_q;
      it_count_d = it_count_q;
      last_step  = 1'b0;

      // Launch wins over a running operation and over its finishing step.
      if (bus.launch) begin
         mcand_d    = {{WIDTH{1'b0}}, bus.multiplicand};
         mplr_d     = bus.multiplier;
         acc_d      = '0;
         it_count_d = '0;
         state_d    = StRun;
`ifdef MULTIPLIER_EARLY_EXIT_EN
         if (bus.multiplier == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
`endif
      end else begin
         unique case (state_q)
            StRun: begin
               if (mplr_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d    = mcand_q << 1;
               mplr_d     = mplr_q >> 1;
               it_count_d = it_count_q + CntW'(1);
               last_step  = (it_count_q == LastCnt);
`ifdef MULTIPLIER_EARLY_EXIT_EN
               last_step  = last_step || (mplr_d == '0);
`endif
               if (last_step) begin
                  state_d    = StIdle;
                  done_d     = 1'b1;
                  it_count_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state_q == StRun);
   assign bus.done    = done_q;
   assign bus.product = acc_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the multiplier at WIDTH=4; latency expectations follow
// whether MULTIPLIER_EARLY_EXIT_EN is defined for the build.
module tb_multiplier;

   localparam int unsigned W = 4;
`ifdef MULTIPLIER_EARLY_EXIT_EN
   localparam bit EarlyExit = 1'b1;
`else
   localparam bit EarlyExit = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   multiplier_if #(.WIDTH(W)) bus ();

   multiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Edges after the launch edge until done shows: WIDTH, or highest set bit + 1 with early exit.
   function automatic int exp_lat(input int b);
      int lat;
      if (!EarlyExit) return W;
      lat = 0;
      for (int i = 0; i < W; i++) if (b[i]) lat = i + 1;
      return lat;
   endfunction

   task automatic launch_op(input int a, input int b);
      bus.multiplicand = W'(a);
      bus.multiplier   = W'(b);
      bus.launch       = 1'b1;
      tick();
      bus.launch       = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_l, input int exp_p);
      int n;
      n = 0;
      while (!bus.done && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(exp_l));
      check({tag, "_product"}, 64'(bus.product), 64'(exp_p));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      bus.launch = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier = '0;
      tick();
      tick();
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_product", 64'(bus.product), 64'd0);
      reset = 1'b1;

      // 13 x 11: busy for exactly four cycles in the default build.
      launch_op(13, 11);
      check("basic_busy_e0", 64'(bus.busy), 64'd1);
      check("basic_done_e0", 64'(bus.done), 64'd0);
      wait_done("basic", exp_lat(11), 143);
      check("basic_busy_at_done", 64'(bus.busy), 64'd0);
      tick();
      check("done_one_cycle", 64'(bus.done), 64'd0);
      check("product_holds", 64'(bus.product), 64'd143);

      // Maximum operands, then back-to-back launch in the done cycle.
      launch_op(15, 15);
      wait_done("max", exp_lat(15), 225);
      launch_op(2, 3);
      check("b2b_done_e0", 64'(bus.done), 64'd0);
      check("b2b_busy_e0", 64'(bus.busy), 64'd1);
      wait_done("b2b", exp_lat(3), 6);

      // Relaunch 5 x 6 after two steps of 9 x 9; 9 x 9 must never report.
      launch_op(9, 9);
      tick();
      tick();
      check("relaunch_no_done", 64'(bus.done), 64'd0);
      launch_op(5, 6);
      wait_done("relaunch", exp_lat(6), 30);

      // Reset after two steps of 9 x 9 discards the partial sum.
      launch_op(9, 9);
      tick();
      tick();
      check("partial_product", 64'(bus.product), 64'd9);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("midreset_busy", 64'(bus.busy), 64'd0);
      check("midreset_done", 64'(bus.done), 64'd0);
      check("midreset_product", 64'(bus.product), 64'd0);
      tick();
      check("post_reset_idle_busy", 64'(bus.busy), 64'd0);

      // Operands changed while busy have no effect.
      bus.multiplicand = W'(7);
      bus.multiplier   = W'(3);
      bus.launch       = 1'b1;
      tick();
      bus.launch       = 1'b0;
      bus.multiplicand = W'(15);
      bus.multiplier   = W'(15);
      wait_done("toggle", exp_lat(3), 21);

      // Launch on the finishing edge restarts with no done.
      launch_op(13, 11);
      tick();
      tick();
      tick();
      bus.multiplicand = W'(2);
      bus.multiplier   = W'(3);
      bus.launch       = 1'b1;
      tick();
      bus.launch       = 1'b0;
      check("finish_relaunch_done", 64'(bus.done), 64'd0);
      check("finish_relaunch_busy", 64'(bus.busy), 64'd1);
      wait_done("finish_relaunch", exp_lat(3), 6);

      // Early-exit sensitive operands.
      launch_op(7, 1);
      wait_done("b_one", exp_lat(1), 7);
      launch_op(9, 0);
      wait_done("b_zero", exp_lat(0), 0);
      tick();
      check("b_zero_idle_done", 64'(bus.done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
